// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - ALU codes, field constants and control bundle for the decode/issue stage
package mips_ctrl_pkg;
  localparam int ALU_W = 5;

  localparam logic [ALU_W-1:0] ALU_AND  = 5'd0,  ALU_OR   = 5'd1,  ALU_ADD  = 5'd2,  ALU_NOT  = 5'd3;
  localparam logic [ALU_W-1:0] ALU_XOR  = 5'd4,  ALU_MUL  = 5'd5,  ALU_SUB  = 5'd6,  ALU_SLT  = 5'd7;
  localparam logic [ALU_W-1:0] ALU_ADDU = 5'd8,  ALU_SUBU = 5'd9,  ALU_BLEU = 5'd10, ALU_SEQ  = 5'd11;
  localparam logic [ALU_W-1:0] ALU_SRA  = 5'd12, ALU_SLL  = 5'd13, ALU_SRL  = 5'd14, ALU_SLA  = 5'd15;
  localparam logic [ALU_W-1:0] ALU_BNE  = 5'd16, ALU_BGTU = 5'd17, ALU_BGTE = 5'd18, ALU_BLEQ = 5'd19;
  localparam logic [ALU_W-1:0] ALU_BGT  = 5'd20;

  localparam logic [5:0] FUNC_SLL = 6'h00, FUNC_SRL = 6'h02, FUNC_SRA = 6'h03, FUNC_SLA = 6'h04;
  localparam logic [5:0] FUNC_MUL = 6'h18, FUNC_ADD = 6'h20, FUNC_ADDU = 6'h21, FUNC_SUB = 6'h22;
  localparam logic [5:0] FUNC_SUBU = 6'h23, FUNC_AND = 6'h24, FUNC_OR = 6'h25, FUNC_XOR = 6'h26;
  localparam logic [5:0] FUNC_NOT = 6'h27, FUNC_SLT = 6'h2A, FUNC_SEQ = 6'h2B;

  localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E;
  localparam logic [5:0] OP_BGTE = 6'h12, OP_BLT = 6'h13, OP_BLEQ = 6'h14, OP_BLEU = 6'h15;
  localparam logic [5:0] OP_BGTU = 6'h16, OP_BGT = 6'h17;

  localparam logic [1:0] TYPE_R = 2'd0, TYPE_I = 2'd1;
  localparam logic [1:0] SRC2_RT = 2'd0, SRC2_IMM = 2'd1, SRC2_SHAMT = 2'd2, SRC2_ZERO = 2'd3;

  typedef struct packed {
    logic [ALU_W-1:0] alu_ctrl;
    logic [1:0]       src2_sel;
    logic             branch;
    logic             second_read;
    logic             write_en;
    logic             hilo_we;
    logic             illegal;
    logic             is_mul;
  } ctrl_t;

  typedef enum logic {IDLE, MUL_WAIT} issue_state_t;

  localparam ctrl_t ILLEGAL_CTRL = '{alu_ctrl: '0, src2_sel: SRC2_ZERO, branch: 1'b0,
                                     second_read: 1'b0, write_en: 1'b0, hilo_we: 1'b0,
                                     illegal: 1'b1, is_mul: 1'b0};

  function automatic ctrl_t mk_ctrl(input logic [ALU_W-1:0] alu, input logic [1:0] src2,
                                    input logic br, input logic sr, input logic we);
    mk_ctrl = '{alu_ctrl: alu, src2_sel: src2, branch: br, second_read: sr, write_en: we,
                hilo_we: 1'b0, illegal: 1'b0, is_mul: 1'b0};
  endfunction
endpackage

// File: rtl/decode_lut.sv
// rtl/decode_lut.sv - combinational type/opcode/func to control bundle table
module decode_lut
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] typ,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl = ILLEGAL_CTRL;
    if (typ == TYPE_R) begin
      case (func)
        FUNC_ADD:  ctrl = mk_ctrl(ALU_ADD,  SRC2_RT, 1'b0, 1'b1, 1'b1);
        FUNC_SUB:  ctrl = mk_ctrl(ALU_SUB,  SRC2_RT, 1'b0, 1'b1, 1'b1);
        FUNC_ADDU: ctrl = mk_ctrl(ALU_ADDU, SRC2_RT, 1'b0, 1'b1, 1'b1);
        FUNC_SUBU: ctrl = mk_ctrl(ALU_SUBU, SRC2_RT, 1'b0, 1'b1, 1'b1);
        FUNC_AND:  ctrl = mk_ctrl(ALU_AND,  SRC2_RT, 1'b0, 1'b1, 1'b1);
        FUNC_OR:   ctrl = mk_ctrl(ALU_OR,   SRC2_RT, 1'b0, 1'b1, 1'b1);
        FUNC_XOR:  ctrl = mk_ctrl(ALU_XOR,  SRC2_RT, 1'b0, 1'b1, 1'b1);
        FUNC_SLT:  ctrl = mk_ctrl(ALU_SLT,  SRC2_RT, 1'b0, 1'b1, 1'b1);
        FUNC_SEQ:  ctrl = mk_ctrl(ALU_SEQ,  SRC2_RT, 1'b0, 1'b1, 1'b1);
        FUNC_NOT:  ctrl = mk_ctrl(ALU_NOT,  SRC2_ZERO, 1'b0, 1'b0, 1'b1);
        FUNC_SLL:  ctrl = mk_ctrl(ALU_SLL,  SRC2_SHAMT, 1'b0, 1'b0, 1'b1);
        FUNC_SRL:  ctrl = mk_ctrl(ALU_SRL,  SRC2_SHAMT, 1'b0, 1'b0, 1'b1);
        FUNC_SRA:  ctrl = mk_ctrl(ALU_SRA,  SRC2_SHAMT, 1'b0, 1'b0, 1'b1);
        FUNC_SLA:  ctrl = mk_ctrl(ALU_SLA,  SRC2_SHAMT, 1'b0, 1'b0, 1'b1);
        FUNC_MUL: begin
          // product lands in HI/LO, not the register file
          ctrl         = mk_ctrl(ALU_MUL, SRC2_RT, 1'b0, 1'b1, 1'b0);
          ctrl.hilo_we = 1'b1;
          ctrl.is_mul  = 1'b1;
        end
        default: ;
      endcase
    end else if (typ == TYPE_I) begin
      case (opcode)
        OP_ADDI:  ctrl = mk_ctrl(ALU_ADD,  SRC2_IMM, 1'b0, 1'b0, 1'b1);
        OP_ADDIU: ctrl = mk_ctrl(ALU_ADDU, SRC2_IMM, 1'b0, 1'b0, 1'b1);
        OP_ANDI:  ctrl = mk_ctrl(ALU_AND,  SRC2_IMM, 1'b0, 1'b0, 1'b1);
        OP_ORI:   ctrl = mk_ctrl(ALU_OR,   SRC2_IMM, 1'b0, 1'b0, 1'b1);
        OP_XORI:  ctrl = mk_ctrl(ALU_XOR,  SRC2_IMM, 1'b0, 1'b0, 1'b1);
        OP_SLTI:  ctrl = mk_ctrl(ALU_SLT,  SRC2_IMM, 1'b0, 1'b0, 1'b1);
        OP_BEQ:   ctrl = mk_ctrl(ALU_SEQ,  SRC2_RT, 1'b1, 1'b1, 1'b0);
        OP_BNE:   ctrl = mk_ctrl(ALU_BNE,  SRC2_RT, 1'b1, 1'b1, 1'b0);
        OP_BGTE:  ctrl = mk_ctrl(ALU_BGTE, SRC2_RT, 1'b1, 1'b1, 1'b0);
        OP_BLT:   ctrl = mk_ctrl(ALU_SLT,  SRC2_RT, 1'b1, 1'b1, 1'b0);
        OP_BLEQ:  ctrl = mk_ctrl(ALU_BLEQ, SRC2_RT, 1'b1, 1'b1, 1'b0);
        OP_BLEU:  ctrl = mk_ctrl(ALU_BLEU, SRC2_RT, 1'b1, 1'b1, 1'b0);
        OP_BGTU:  ctrl = mk_ctrl(ALU_BGTU, SRC2_RT, 1'b1, 1'b1, 1'b0);
        OP_BGT:   ctrl = mk_ctrl(ALU_BGT,  SRC2_RT, 1'b1, 1'b1, 1'b0);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/decode_issue_stage.sv
// rtl/decode_issue_stage.sv - registered decode/issue stage with handshake, flush and multiply interlock
module decode_issue_stage
  import mips_ctrl_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int ALUCTRL_W = 5,
  parameter int MUL_LAT   = 4,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_type,
  input  logic [5:0]           in_opcode,
  input  logic [5:0]           in_func,
  input  logic [REG_AW-1:0]    in_rs,
  input  logic [REG_AW-1:0]    in_rt,
  input  logic [REG_AW-1:0]    in_rd,
  input  logic [4:0]           in_shamt,
  input  logic [DATA_W-1:0]    in_imm,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ALUCTRL_W-1:0] out_alu_ctrl,
  output logic [REG_AW-1:0]    out_rs,
  output logic [REG_AW-1:0]    out_rt,
  output logic [REG_AW-1:0]    out_wr_idx,
  output logic [1:0]           out_src2_sel,
  output logic [DATA_W-1:0]    out_imm,
  output logic                 out_branch,
  output logic                 out_second_read,
  output logic                 out_write_en,
  output logic                 out_hilo_we,
  output logic                 out_illegal,
  output logic                 mul_busy,
  output logic [CNT_W-1:0]     illegal_cnt
);
  localparam int MC_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  ctrl_t        dec;
  issue_state_t state, state_nxt;
  logic [MC_W-1:0] mul_cnt, mul_cnt_nxt;
  logic         accept;

  decode_lut u_decode_lut (
    .typ    (in_type),
    .opcode (in_opcode),
    .func   (in_func),
    .ctrl   (dec)
  );

  assign mul_busy = (state == MUL_WAIT);
  // rst_n gates in_ready so nothing is taken while the stage is held in reset
  assign in_ready = rst_n & (~out_valid | out_ready) & ~mul_busy & ~flush;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      out_alu_ctrl    <= '0;
      out_rs          <= '0;
      out_rt          <= '0;
      out_wr_idx      <= '0;
      out_src2_sel    <= '0;
      out_imm         <= '0;
      out_branch      <= 1'b0;
      out_second_read <= 1'b0;
      out_write_en    <= 1'b0;
      out_hilo_we     <= 1'b0;
      out_illegal     <= 1'b0;
      illegal_cnt     <= '0;
    end else begin
      if (accept) begin
        out_valid       <= 1'b1;
        out_alu_ctrl    <= ALUCTRL_W'(dec.alu_ctrl);
        out_rs          <= in_rs;
        out_rt          <= in_rt;
        out_wr_idx      <= (in_type == TYPE_R) ? in_rd : in_rt;
        out_src2_sel    <= dec.src2_sel;
        out_imm         <= (dec.src2_sel == SRC2_SHAMT) ? DATA_W'(in_shamt) : in_imm;
        out_branch      <= dec.branch;
        out_second_read <= dec.second_read;
        out_write_en    <= dec.write_en;
        out_hilo_we     <= dec.hilo_we;
        out_illegal     <= dec.illegal;
      end else if (flush | out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && dec.illegal && (illegal_cnt != '1)) illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mul_cnt <= '0;
    end else begin
      state   <= state_nxt;
      mul_cnt <= mul_cnt_nxt;
    end
  end

  // flush deliberately leaves MUL_WAIT alone: the multiplier is still physically busy
  always_comb begin
    state_nxt   = state;
    mul_cnt_nxt = mul_cnt;
    case (state)
      IDLE: begin
        if (accept && dec.is_mul && (MUL_LAT > 1)) begin
          state_nxt   = MUL_WAIT;
          mul_cnt_nxt = MC_W'(MUL_LAT - 1);
        end
      end
      MUL_WAIT: begin
        if (mul_cnt == MC_W'(1)) state_nxt = IDLE;
        else mul_cnt_nxt = mul_cnt - MC_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_decode_issue_stage.sv
// tb/tb_decode_issue_stage.sv - self-checking bench for decode_issue_stage
module tb_decode_issue_stage;
  localparam int MUL_LAT = 4;

  logic        clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [1:0]  in_type, out_src2_sel;
  logic [5:0]  in_opcode, in_func;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt, out_alu_ctrl, out_rs, out_rt, out_wr_idx;
  logic [31:0] in_imm, out_imm;
  logic        out_branch, out_second_read, out_write_en, out_hilo_we, out_illegal, mul_busy;
  logic [7:0]  illegal_cnt;

  decode_issue_stage #(.DATA_W(32), .REG_AW(5), .ALUCTRL_W(5), .MUL_LAT(MUL_LAT), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_opcode(in_opcode), .in_func(in_func), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_alu_ctrl(out_alu_ctrl), .out_rs(out_rs), .out_rt(out_rt),
    .out_wr_idx(out_wr_idx), .out_src2_sel(out_src2_sel), .out_imm(out_imm),
    .out_branch(out_branch), .out_second_read(out_second_read), .out_write_en(out_write_en),
    .out_hilo_we(out_hilo_we), .out_illegal(out_illegal), .mul_busy(mul_busy),
    .illegal_cnt(illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] alu; logic [4:0] rs; logic [4:0] rt; logic [4:0] wr; logic [1:0] src2;
    logic [31:0] imm; logic br; logic sr; logic we; logic hilo; logic ill;
  } obs_t;

  typedef struct {
    logic [5:0] code; logic [4:0] alu; logic [1:0] src2; logic br; logic sr; logic we; logic hilo;
  } row_t;

  typedef struct {
    logic [1:0] typ; logic [5:0] op; logic [5:0] fn; logic [4:0] rs; logic [4:0] rt; logic [4:0] rd;
    logic [4:0] sh; logic [31:0] imm; obs_t exp;
  } vec_t;

  row_t rtab[$], itab[$];
  vec_t vecs[$];
  int   errors = 0, checks = 0;

  obs_t m_obs;
  bit   m_valid;
  int   m_busy, m_cnt;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic row_t R(input logic [5:0] c, input int alu, input int s2, input bit br,
                             input bit sr, input bit we, input bit hl);
    row_t r;
    r.code = c; r.alu = alu[4:0]; r.src2 = s2[1:0]; r.br = br; r.sr = sr; r.we = we; r.hilo = hl;
    return r;
  endfunction

  function automatic obs_t ref_decode(input logic [1:0] t, input logic [5:0] op, input logic [5:0] fn,
                                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [4:0] sh, input logic [31:0] imm);
    obs_t o;
    o = '0;
    o.rs = rs; o.rt = rt; o.wr = (t == 2'd0) ? rd : rt; o.imm = imm; o.src2 = 2'd3; o.ill = 1'b1;
    if (t == 2'd0) begin
      foreach (rtab[i]) if (rtab[i].code == fn) begin
        o.alu = rtab[i].alu; o.src2 = rtab[i].src2; o.br = rtab[i].br; o.sr = rtab[i].sr;
        o.we = rtab[i].we; o.hilo = rtab[i].hilo; o.ill = 1'b0;
      end
    end else if (t == 2'd1) begin
      foreach (itab[i]) if (itab[i].code == op) begin
        o.alu = itab[i].alu; o.src2 = itab[i].src2; o.br = itab[i].br; o.sr = itab[i].sr;
        o.we = itab[i].we; o.hilo = itab[i].hilo; o.ill = 1'b0;
      end
    end
    if (o.src2 == 2'd2) o.imm = {27'd0, sh};
    return o;
  endfunction

  function automatic vec_t V(input int t, input int op, input int fn, input int rs, input int rt,
                             input int rd, input int sh, input int imm, input int alu, input int wr,
                             input int s2, input int eimm, input bit br, input bit sr, input bit we,
                             input bit ill);
    vec_t v;
    v.typ = t[1:0]; v.op = op[5:0]; v.fn = fn[5:0]; v.rs = rs[4:0]; v.rt = rt[4:0]; v.rd = rd[4:0];
    v.sh = sh[4:0]; v.imm = imm;
    v.exp = '{alu: alu[4:0], rs: rs[4:0], rt: rt[4:0], wr: wr[4:0], src2: s2[1:0], imm: eimm,
              br: br, sr: sr, we: we, hilo: 1'b0, ill: ill};
    return v;
  endfunction

  function automatic obs_t observe();
    return {out_alu_ctrl, out_rs, out_rt, out_wr_idx, out_src2_sel, out_imm,
            out_branch, out_second_read, out_write_en, out_hilo_we, out_illegal};
  endfunction

  task automatic drive(input logic [1:0] t, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [4:0] sh, input logic [31:0] imm);
    in_valid = 1'b1; in_type = t; in_opcode = op; in_func = fn;
    in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_imm = imm;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(2'd0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_mul_busy", mul_busy, 1'b0);
    chk("rst_illegal_cnt", illegal_cnt, 8'd0);
    chk("rst_bundle", observe(), '0);
    tick(); tick();
    rst_n = 1'b1;
    m_obs = '0; m_valid = 0; m_busy = 0; m_cnt = 0;
  endtask

  initial begin
    rtab.push_back(R(6'h20, 2, 0, 0, 1, 1, 0));  rtab.push_back(R(6'h22, 6, 0, 0, 1, 1, 0));
    rtab.push_back(R(6'h21, 8, 0, 0, 1, 1, 0));  rtab.push_back(R(6'h23, 9, 0, 0, 1, 1, 0));
    rtab.push_back(R(6'h24, 0, 0, 0, 1, 1, 0));  rtab.push_back(R(6'h25, 1, 0, 0, 1, 1, 0));
    rtab.push_back(R(6'h26, 4, 0, 0, 1, 1, 0));  rtab.push_back(R(6'h2A, 7, 0, 0, 1, 1, 0));
    rtab.push_back(R(6'h2B, 11, 0, 0, 1, 1, 0)); rtab.push_back(R(6'h27, 3, 3, 0, 0, 1, 0));
    rtab.push_back(R(6'h00, 13, 2, 0, 0, 1, 0)); rtab.push_back(R(6'h02, 14, 2, 0, 0, 1, 0));
    rtab.push_back(R(6'h03, 12, 2, 0, 0, 1, 0)); rtab.push_back(R(6'h04, 15, 2, 0, 0, 1, 0));
    rtab.push_back(R(6'h18, 5, 0, 0, 1, 0, 1));
    itab.push_back(R(6'h08, 2, 1, 0, 0, 1, 0));  itab.push_back(R(6'h09, 8, 1, 0, 0, 1, 0));
    itab.push_back(R(6'h0C, 0, 1, 0, 0, 1, 0));  itab.push_back(R(6'h0D, 1, 1, 0, 0, 1, 0));
    itab.push_back(R(6'h0E, 4, 1, 0, 0, 1, 0));  itab.push_back(R(6'h0A, 7, 1, 0, 0, 1, 0));
    itab.push_back(R(6'h04, 11, 0, 1, 1, 0, 0)); itab.push_back(R(6'h05, 16, 0, 1, 1, 0, 0));
    itab.push_back(R(6'h12, 18, 0, 1, 1, 0, 0)); itab.push_back(R(6'h13, 7, 0, 1, 1, 0, 0));
    itab.push_back(R(6'h14, 19, 0, 1, 1, 0, 0)); itab.push_back(R(6'h15, 10, 0, 1, 1, 0, 0));
    itab.push_back(R(6'h16, 17, 0, 1, 1, 0, 0)); itab.push_back(R(6'h17, 20, 0, 1, 1, 0, 0));

    //          typ op    fn    rs rt rd sh  imm      alu wr s2 eimm     br sr we ill
    vecs.push_back(V(0, 0,    'h20, 1, 2, 3, 0,  0,       2,  3, 0, 0,       0, 1, 1, 0));
    vecs.push_back(V(1, 'h08, 0,    1, 4, 7, 0,  1000,    2,  4, 1, 1000,    0, 0, 1, 0));
    vecs.push_back(V(1, 'h04, 0,    4, 5, 0, 0,  16,      11, 5, 0, 16,      1, 1, 0, 0));
    vecs.push_back(V(0, 0,    'h00, 0, 6, 7, 3,  'hFFFF,  13, 7, 2, 3,       0, 0, 1, 0));
    vecs.push_back(V(0, 0,    'h27, 2, 0, 8, 0,  5,       3,  8, 3, 5,       0, 0, 1, 0));
    vecs.push_back(V(0, 0,    'h2A, 9, 10, 11, 0, 0,      7,  11, 0, 0,      0, 1, 1, 0));
    vecs.push_back(V(1, 'h17, 0,    3, 2, 1, 0,  -4,      20, 2, 0, -4,      1, 1, 0, 0));
    vecs.push_back(V(1, 'h15, 0,    6, 7, 8, 0,  8,       10, 7, 0, 8,       1, 1, 0, 0));
    vecs.push_back(V(1, 'h0E, 0,    12, 13, 14, 0, 'hFF,  4,  13, 1, 'hFF,   0, 0, 1, 0));
    vecs.push_back(V(0, 0,    'h3F, 1, 2, 15, 0, 77,      0,  15, 3, 77,     0, 0, 0, 1));
    vecs.push_back(V(3, 'h08, 'h20, 1, 2, 16, 0, 9,       0,  2, 3, 9,       0, 0, 0, 1));
    vecs.push_back(V(1, 'h00, 0,    1, 17, 18, 0, 1,      0,  17, 3, 1,      0, 0, 0, 1));
    vecs.push_back(V(0, 0,    'h03, 0, 19, 20, 31, 0,     12, 20, 2, 31,     0, 0, 1, 0));
    vecs.push_back(V(1, 'h16, 0,    21, 22, 0, 0, 3,      17, 22, 0, 3,      1, 1, 0, 0));

    do_reset();

    // back-to-back table vectors at full throughput
    foreach (vecs[i]) begin
      drive(vecs[i].typ, vecs[i].op, vecs[i].fn, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].imm);
      #1;
      chk($sformatf("vec%0d_in_ready", i), in_ready, 1'b1);
      tick();
      chk($sformatf("vec%0d_out_valid", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_bundle", i), observe(), vecs[i].exp);
    end
    in_valid = 1'b0;
    chk("vec_illegal_cnt", illegal_cnt, 8'd3);
    tick();

    // multiply interlock
    drive(2'd0, 6'd0, 6'h18, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
    #1;
    chk("mul_in_ready", in_ready, 1'b1);
    tick();
    chk("mul_alu", out_alu_ctrl, 5'd5);
    chk("mul_hilo_we", {out_hilo_we, out_write_en, out_second_read}, 3'b101);
    drive(2'd0, 6'd0, 6'h20, 5'd4, 5'd5, 5'd6, 5'd0, 32'd0);
    for (int c = 0; c < MUL_LAT - 1; c++) begin
      #1;
      chk($sformatf("mul_busy_c%0d", c), mul_busy, 1'b1);
      chk($sformatf("mul_in_ready_c%0d", c), in_ready, 1'b0);
      tick();
    end
    #1;
    chk("mul_done_busy", mul_busy, 1'b0);
    chk("mul_done_in_ready", in_ready, 1'b1);
    tick();
    chk("after_mul_alu", {out_valid, out_alu_ctrl, out_wr_idx}, {1'b1, 5'd2, 5'd6});
    in_valid = 1'b0;
    tick();

    // backpressure holds an sll
    out_ready = 1'b0;
    drive(2'd0, 6'd0, 6'h00, 5'd0, 5'd3, 5'd9, 5'd10, 32'hDEAD);
    #1;
    tick();
    drive(2'd1, 6'h08, 6'd0, 5'd1, 5'd4, 5'd0, 5'd0, 32'd1000);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp_in_ready_c%0d", c), in_ready, 1'b0);
      chk($sformatf("bp_hold_c%0d", c), {out_valid, out_alu_ctrl, out_src2_sel, out_imm, out_wr_idx},
          {1'b1, 5'd13, 2'd2, 32'd10, 5'd9});
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1'b1);
    tick();
    chk("bp_next", {out_valid, out_alu_ctrl, out_src2_sel, out_imm, out_wr_idx},
        {1'b1, 5'd2, 2'd1, 32'd1000, 5'd4});
    in_valid = 1'b0;
    tick();

    // flush while holding
    out_ready = 1'b0;
    drive(2'd0, 6'd0, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
    #1;
    tick();
    chk("fl_held", out_valid, 1'b1);
    drive(2'd1, 6'h09, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 32'd5);
    flush = 1'b1;
    #1;
    chk("fl_in_ready", in_ready, 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_cleared", out_valid, 1'b0);
    tick();
    chk("fl_dropped", out_valid, 1'b0);
    out_ready = 1'b1;

    // asynchronous reset in the middle of MUL_WAIT
    drive(2'd0, 6'd0, 6'h18, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
    #1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rmw_busy", mul_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rmw_out_valid", out_valid, 1'b0);
    chk("rmw_mul_busy", mul_busy, 1'b0);
    chk("rmw_illegal_cnt", illegal_cnt, 8'd0);
    chk("rmw_in_ready", in_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // illegal counter saturation
    for (int i = 0; i < 300; i++) begin
      drive(2'd2, 6'($urandom), 6'($urandom), 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
      #1;
      tick();
      chk($sformatf("ill%0d_flag", i), {out_valid, out_illegal}, 2'b11);
      chk($sformatf("ill%0d_cnt", i), illegal_cnt, (i + 1 > 255) ? 255 : i + 1);
    end
    in_valid = 1'b0;

    // random traffic against the reference model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      logic [1:0] t; logic [5:0] op, fn; logic [4:0] rs, rt, rd, sh; logic [31:0] imm;
      bit iv, ordy, fl, exp_ready, acc;
      int pick;
      t = 2'($urandom); op = 6'($urandom); fn = 6'($urandom);
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom); imm = $urandom;
      pick = $urandom_range(9);
      if (pick < 4) begin t = 2'd0; fn = rtab[$urandom_range(rtab.size() - 1)].code; end
      else if (pick < 7) begin t = 2'd1; op = itab[$urandom_range(itab.size() - 1)].code; end
      iv = ($urandom_range(3) != 0);
      ordy = ($urandom_range(3) != 0);
      fl = ($urandom_range(9) == 0);
      drive(t, op, fn, rs, rt, rd, sh, imm);
      in_valid = iv; out_ready = ordy; flush = fl;
      #1;
      exp_ready = (!m_valid || ordy) && (m_busy == 0) && !fl;
      acc = iv && exp_ready;
      chk("rnd_in_ready", in_ready, exp_ready);
      tick();
      if (acc) begin
        m_obs = ref_decode(t, op, fn, rs, rt, rd, sh, imm);
        m_valid = 1;
        if (m_obs.ill && m_cnt < 255) m_cnt++;
      end else if (fl || ordy) begin
        m_valid = 0;
      end
      if (acc && t == 2'd0 && fn == 6'h18) m_busy = MUL_LAT - 1;
      else if (m_busy > 0) m_busy--;
      chk("rnd_out_valid", out_valid, m_valid);
      chk("rnd_mul_busy", mul_busy, m_busy > 0);
      chk("rnd_illegal_cnt", illegal_cnt, m_cnt);
      chk("rnd_bundle", observe(), m_obs);
    end
    in_valid = 1'b0; flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
